// File: rtl/dco_trim_controller.sv
// Digital trim loop for a DCO: measures the reference period in hiclock cycles and
// nudges a 0..26 thermometer trim code until the period matches {div,1'b0}.
module dco_trim_controller #(
    parameter int unsigned INIT_TVAL = 13,
    parameter int unsigned DEADBAND  = 0,
    parameter int unsigned LOCK_CNT  = 4
) (
    input  logic        hiclock,
    input  logic        reset,
    input  logic        ref_clk,
    input  logic        enable,
    input  logic [4:0]  div,
    input  logic        ext_sel,
    input  logic [25:0] ext_trim,
    output logic [25:0] trim,
    output logic        locked
);

    localparam logic [4:0] TVAL_MAX = 5'd26;
    localparam logic [6:0] CNT_MAX  = 7'd127;

    // Code k turns on ceil(k/2) low-half cells and floor(k/2) high-half cells.
    function automatic logic [25:0] therm(input logic [4:0] k);
        logic [25:0] m;
        int          lo_n;
        int          hi_n;
        m    = '0;
        lo_n = (int'(k) + 1) / 2;
        hi_n = int'(k) / 2;
        for (int j = 0; j < 13; j++) begin
            m[j]      = (j < lo_n);
            m[13 + j] = (j < hi_n);
        end
        return m;
    endfunction

    logic [1:0] sync;
    logic       hist;
    logic       rise;
    logic [6:0] cnt;
    logic       valid;
    logic [4:0] tval;
    logic [3:0] lock_cnt;

    logic [5:0]        target;
    logic [8:0]        hi_bound;
    logic signed [7:0] lo_raw;
    logic [7:0]        lo_bound;
    logic              too_slow;
    logic              too_fast;
    logic              measure;
    logic              loop_off;

    assign rise = sync[1] & ~hist;

    always_ff @(posedge hiclock or posedge reset) begin
        if (reset) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[0], ref_clk};
            hist <= sync[1];
        end
    end

    // The pre-update count is the measured period on a rise cycle.
    always_ff @(posedge hiclock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (rise)
            cnt <= 7'd1;
        else if (cnt != CNT_MAX)
            cnt <= cnt + 7'd1;
    end

    assign target   = {div, 1'b0};
    assign hi_bound = {3'b000, target} + 9'(DEADBAND);
    assign lo_raw   = $signed({2'b00, target}) - $signed(8'(DEADBAND));
    assign lo_bound = (lo_raw < 0) ? 8'd0 : lo_raw;
    assign too_slow = ({2'b00, cnt} > hi_bound);
    assign too_fast = ({1'b0, cnt} < lo_bound);
    assign loop_off = ~enable | ext_sel;
    assign measure  = rise & valid & ~loop_off & (div != 5'd0);

    // The first rise after enabling (or after an override) only arms the measurement.
    always_ff @(posedge hiclock or posedge reset) begin
        if (reset)
            valid <= 1'b0;
        else if (loop_off)
            valid <= 1'b0;
        else if (rise)
            valid <= 1'b1;
    end

    always_ff @(posedge hiclock or posedge reset) begin
        if (reset) begin
            tval <= 5'(INIT_TVAL);
        end else if (measure) begin
            if (too_slow && tval != TVAL_MAX)
                tval <= tval + 5'd1;
            else if (too_fast && tval != 5'd0)
                tval <= tval - 5'd1;
        end
    end

    // Saturation-blocked adjustments still count as out of band.
    always_ff @(posedge hiclock or posedge reset) begin
        if (reset)
            lock_cnt <= '0;
        else if (loop_off || div == 5'd0)
            lock_cnt <= '0;
        else if (measure) begin
            if (too_slow || too_fast)
                lock_cnt <= '0;
            else if (lock_cnt != 4'd15)
                lock_cnt <= lock_cnt + 4'd1;
        end
    end

    always_ff @(posedge hiclock or posedge reset) begin
        if (reset) begin
            locked <= 1'b0;
            trim   <= therm(5'(INIT_TVAL));
        end else begin
            locked <= ~loop_off & (lock_cnt >= 4'(LOCK_CNT));
            trim   <= ext_sel ? ext_trim : therm(tval);
        end
    end

endmodule
